// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, frame geometry, divider calculation.
// Kept separate so the future uart_rx can reuse the same encodings and divider rule.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Clocks per bit; callers must choose rates giving an integer result of at least 2.
    function automatic int calc_div(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO ahead of the transmit shifter; pointers carry one extra wrap bit for full/empty.
// Read data is registered: a byte appears on rd_data the cycle after rd_en.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int WIDTH      = DATA_BITS,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    // NOTE: the storage array has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter, LSB first, DIV = CLK_RATE/BAUD_RATE clocks per bit.
// Define UART_TX_FIFO_EN for a 2^FIFO_DEPTH_LOG2-entry FIFO ahead of the shifter; otherwise a single holding register.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_RATE        = 25000000,
    parameter int BAUD_RATE       = 2500000,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] wdata,
    input  logic       wvalid,
    output logic       wready,
    output logic       busy,
    output logic       ser_tx
);

    localparam int DIV   = calc_div(CLK_RATE, BAUD_RATE);
    localparam int DIV_W = $clog2(DIV);
    localparam int OCC_W = $clog2((1 << FIFO_DEPTH_LOG2) + 2);
`ifdef UART_TX_FIFO_EN
    localparam int CAPACITY = (1 << FIFO_DEPTH_LOG2) + 1;
`else
    localparam int CAPACITY = 2;
`endif

    tx_state_t        state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift_q, shift_next;
    logic             ser_next;
    logic             bit_end;
    logic             load;
    logic             frame_done;
    logic             push;
    logic             byte_avail;
    logic [7:0]       byte_data;
    logic [OCC_W-1:0] occ, occ_next;
    logic             wready_next;

    assign push    = wvalid && wready;
    assign bit_end = (div_cnt == DIV_W'(DIV - 1));

    // Occupancy covers queued bytes plus the frame on the wire; it drops only when a stop bit completes.
    assign occ_next    = occ + OCC_W'(push) - OCC_W'(frame_done);
    assign wready_next = (occ_next < OCC_W'(CAPACITY));
    assign busy        = (state != ST_IDLE) || (occ != '0);

`ifdef UART_TX_FIFO_EN
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       pend;
    logic [7:0] fifo_rd_data;

    // Prefetch one byte into the FIFO output register so the shifter can reload with no idle gap.
    assign fifo_rd_en = !fifo_empty && (!pend || load);
    assign byte_avail = pend;
    assign byte_data  = fifo_rd_data;

    uart_tx_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push && !fifo_full),
        .wr_data (wdata),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
        end else if (fifo_rd_en) begin
            pend <= 1'b1;
        end else if (load) begin
            pend <= 1'b0;
        end
    end
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    assign byte_avail = hold_valid;
    assign byte_data  = hold_data;

    // A push can only coincide with a load (holding register being emptied), so push wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= wdata;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            ser_tx  <= 1'b1;
            occ     <= '0;
            wready  <= 1'b1;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            bit_cnt <= bit_next;
            shift_q <= shift_next;
            ser_tx  <= ser_next;
            occ     <= occ_next;
            wready  <= wready_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no branch can infer a latch.
        state_next = state;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_q;
        ser_next   = ser_tx;
        load       = 1'b0;
        frame_done = 1'b0;

        case (state)
            ST_IDLE: begin
                div_next = '0;
                if (byte_avail) begin
                    state_next = ST_START;
                    load       = 1'b1;
                    shift_next = byte_data;
                    ser_next   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    div_next   = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                    ser_next   = shift_q[0];
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_next   = '0;
                    bit_next   = bit_cnt + 3'd1;
                    shift_next = {1'b1, shift_q[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_STOP;
                        ser_next   = 1'b1;
                    end else begin
                        ser_next = shift_q[1];
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    div_next   = '0;
                    frame_done = 1'b1;
                    if (byte_avail) begin
                        state_next = ST_START;
                        load       = 1'b1;
                        shift_next = byte_data;
                        ser_next   = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        ser_next   = 1'b1;
                    end
                end else begin
                    div_next = div_cnt + DIV_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a mid-bit serial decoder and byte queues act as the reference model.
// Directed cases (reset, 0x55, "Hi", backpressure, mid-frame reset, 0x0A) are followed by random traffic.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int CLK_RATE        = 25000000;
    localparam int BAUD_RATE       = 2500000;
    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int DIV             = CLK_RATE / BAUD_RATE;
    localparam int FRAME_CLKS      = FRAME_BITS * DIV;
`ifdef UART_TX_FIFO_EN
    localparam int CAPACITY  = (1 << FIFO_DEPTH_LOG2) + 1;
    localparam int START_LAT = 2;
`else
    localparam int CAPACITY  = 2;
    localparam int START_LAT = 1;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       wvalid  = 1'b0;
    logic [7:0] wdata   = 8'h00;
    logic       wready;
    logic       busy;
    logic       ser_tx;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         cyc        = 0;
    int         last_start = -1;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         start_q[$];

    uart_tx #(
        .CLK_RATE        (CLK_RATE),
        .BAUD_RATE       (BAUD_RATE),
        .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wdata   (wdata),
        .wvalid  (wvalid),
        .wready  (wready),
        .busy    (busy),
        .ser_tx  (ser_tx)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line decoder: finds a falling edge, samples each bit mid-way and checks it holds for DIV clocks.
    initial begin : decoder
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic       cur;
        int         st;
        bits = '0;
        cur  = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && ser_tx === 1'b0) begin
                st         = cyc;
                last_start = cyc;
                stable     = 1'b1;
                aborted    = 1'b0;
                for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                    for (int k = 0; k < DIV; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (reset_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k == 0) cur = ser_tx;
                        else if (ser_tx !== cur) stable = 1'b0;
                        if (k == DIV / 2) bits[b] = ser_tx;
                    end
                end
                if (!aborted) begin
                    check("bit_width", 32'(stable), 32'd1);
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[9]), 32'd1);
                    got_q.push_back(bits[8:1]);
                    start_q.push_back(st);
                    if (bits[8:1] >= 8'h20 && bits[8:1] < 8'h7f) $display("rx: %c", bits[8:1]);
                    else $display("rx: [%0d]", bits[8:1]);
                end else begin
                    wait (reset_n === 1'b1);
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output bit acc, output int acc_cyc);
        wvalid = 1'b1;
        wdata  = b;
        acc    = (wready === 1'b1);
        @(negedge clk);
        acc_cyc = cyc;
        wvalid  = 1'b0;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int n = 0;
        bit acc;
        while (wready !== 1'b1 && n < 3 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check("wready_wait", 32'(wready), 32'd1);
        push_byte(b, acc, acc_cyc);
    endtask

    task automatic wait_idle(input string tag, output int fall_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < 20 * FRAME_CLKS) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(busy), 32'd0);
        fall_cyc = cyc;
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
        start_q.delete();
    endtask

    task automatic apply_reset();
        wvalid  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        start_q.delete();
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not complete (errors so far %0d)", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  acc_cyc;
        int  fall_cyc;
        int  edges;
        int  n;
        int  target;
        bit  acc;
        logic [7:0] rb;

        // Reset values, then a quiet line for 100 clocks.
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ser_tx !== 1'b1) edges++;
        end
        check("idle_line", edges, 0);
        check("idle_busy", 32'(busy), 32'd0);

        // Single byte 0x55: start latency and busy duration.
        send_byte(8'h55, acc_cyc);
        wait_idle("u55", fall_cyc);
        check("u55_frames", start_q.size(), 1);
        if (start_q.size() > 0) begin
            check("u55_latency", start_q[0] - acc_cyc, START_LAT);
            check("u55_busy_len", fall_cyc - start_q[0], FRAME_CLKS);
        end
        compare_queues("u55");

        // Back-to-back "Hi": no idle gap between frames.
        send_byte(8'h48, acc_cyc);
        send_byte(8'h69, acc_cyc);
        wait_idle("hi", fall_cyc);
        check("hi_frames", start_q.size(), 2);
        if (start_q.size() > 1) check("hi_gap", start_q[1] - start_q[0], FRAME_CLKS);
        compare_queues("hi");

        // Backpressure: push every clock; exactly CAPACITY bytes are taken before wready drops.
        for (int i = 0; i <= CAPACITY; i++) begin
            push_byte(8'h30 + 8'(i), acc, acc_cyc);
            check("bp_accept", 32'(acc), 32'(i < CAPACITY));
        end
        wait_idle("bp", fall_cyc);
        check("bp_wready_after", 32'(wready), 32'd1);
        check("bp_accepted", exp_q.size(), CAPACITY);
        compare_queues("bp");

        // Reset during d[3] of 0x41, then 0x42 must arrive cleanly.
        last_start = -1;
        send_byte(8'h41, acc_cyc);
        n = 0;
        while (last_start < 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_start_seen", 32'(last_start >= 0), 32'd1);
        target = last_start + DIV + 3 * DIV + DIV / 2;
        while (cyc < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_d3_level", 32'(ser_tx), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_ser_tx", 32'(ser_tx), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_wready", 32'(wready), 32'd1);
        @(negedge clk);
        apply_reset();
        send_byte(8'h42, acc_cyc);
        wait_idle("mid", fall_cyc);
        compare_queues("mid");

        // Non-printable byte; decoder checks the stop bit holds for a full bit time.
        send_byte(8'h0A, acc_cyc);
        wait_idle("nl", fall_cyc);
        compare_queues("nl");

        // Random traffic with mixed short and long gaps.
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 250);
            else n = $urandom_range(0, 2);
            repeat (n) @(negedge clk);
            send_byte(rb, acc_cyc);
        end
        wait_idle("rnd", fall_cyc);
        compare_queues("rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
